// File: rtl/conv_pkg.sv
// Shared types and constants for the window-buffer sequencer: FSM encoding,
// line-buffer geometry and default window sweep limits.
package conv_pkg;

  localparam int BUF_ROWS      = 4;
  localparam int BUF_WORDS     = 4;
  localparam int WIN_FIRST_DEF = 3;
  localparam int WIN_LAST_DEF  = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SWEEP = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/window_addr_gen.sv
// Fill address generator: keeps a running row base (accumulated, never multiplied)
// and presents a registered word address for the next load.
module window_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic              step_row_i,
  input  logic              step_col_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    stride_d   = stride_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    if (clr_i) begin
      stride_d   = stride_i;
      row_base_d = base_i;
      addr_d     = base_i;
    end else if (step_row_i) begin
      // New row always restarts at column 0, so the address is the new row base.
      row_base_d = row_base_q + stride_q;
      addr_d     = row_base_q + stride_q;
    end else if (step_col_i) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stride_q   <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      stride_q   <= stride_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/window_buffer_ctrl.sv
// Sequencer for the 4x16-byte sliding-window line buffer: fills 16 words from
// image memory, then sweeps the window index and hands each window to the PE.
module window_buffer_ctrl
  import conv_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int WIN_FIRST = WIN_FIRST_DEF,
  parameter int WIN_LAST  = WIN_LAST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  output logic              buf_ld,
  output logic [1:0]        buf_row,
  output logic [1:0]        buf_col,
  output logic [3:0]        buf_index,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              win_last,
  output state_e            state_dbg
);

  localparam logic [3:0] LAST_LOAD = 4'(BUF_ROWS * BUF_WORDS - 1);
  localparam logic [1:0] LAST_COL  = 2'(BUF_WORDS - 1);
  localparam logic [3:0] IDX_FIRST = 4'(WIN_FIRST);
  localparam logic [3:0] IDX_LAST  = 4'(WIN_LAST);

  state_e     state_q, state_d;
  logic [3:0] lc_q, lc_d;
  logic [3:0] idx_q, idx_d;
  logic       addr_clr, step_row, step_col;

  // Handshakes: a transfer happens on a cycle where valid and ready/gnt are both
  // high; the sender holds valid and its payload (mem_addr, buf_index) stable
  // until that cycle. A read request is one transfer; its data returns later on
  // mem_rd_valid, which is only honoured while waiting for it.
  always_comb begin
    state_d  = state_q;
    lc_d     = lc_q;
    idx_d    = idx_q;
    addr_clr = 1'b0;
    step_row = 1'b0;
    step_col = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_clr = 1'b1;
          lc_d     = 4'd0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_rd_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rd_valid) begin
          if (lc_q == LAST_LOAD) begin
            idx_d   = IDX_FIRST;
            state_d = ST_SWEEP;
          end else begin
            lc_d     = lc_q + 4'd1;
            step_row = (lc_q[1:0] == LAST_COL);
            step_col = (lc_q[1:0] != LAST_COL);
            state_d  = ST_REQ;
          end
        end
      end
      ST_SWEEP: begin
        if (win_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = IDX_FIRST;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lc_q    <= 4'd0;
      idx_q   <= IDX_FIRST;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      idx_q   <= idx_d;
    end
  end

  window_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (addr_clr),
    .base_i     (base_addr),
    .stride_i   (row_stride),
    .step_row_i (step_row),
    .step_col_i (step_col),
    .addr_o     (mem_addr)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign mem_rd_req = (state_q == ST_REQ);
  assign buf_ld     = (state_q == ST_WAIT) && mem_rd_valid;
  assign buf_row    = lc_q[3:2];
  assign buf_col    = lc_q[1:0];
  assign buf_index  = idx_q;
  assign win_valid  = (state_q == ST_SWEEP);
  assign win_last   = win_valid && (idx_q == IDX_LAST);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_window_buffer_ctrl.sv
// Bench for window_buffer_ctrl: memory and PE responders, expected-value queues
// filled at job issue and drained by a monitor on the falling edge.
module tb_window_buffer_ctrl;
  import conv_pkg::*;

  logic        clk, rst, start;
  logic [15:0] base_addr, row_stride, mem_addr;
  logic        busy, done, mem_rd_req, mem_rd_gnt, mem_rd_valid, buf_ld;
  logic [1:0]  buf_row, buf_col;
  logic [3:0]  buf_index;
  logic        win_valid, win_ready, win_last;
  state_e      state_dbg;

  window_buffer_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_stride(row_stride),
    .busy(busy), .done(done), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
    .mem_rd_gnt(mem_rd_gnt), .mem_rd_valid(mem_rd_valid), .buf_ld(buf_ld),
    .buf_row(buf_row), .buf_col(buf_col), .buf_index(buf_index), .win_valid(win_valid),
    .win_ready(win_ready), .win_last(win_last), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [15:0] addr_q[$];
  logic [3:0]  ld_q[$];
  logic [3:0]  win_q[$];
  int pass_cnt = 0, total_cnt = 0, done_seen = 0;
  int gnt_dly = 0, rv_dly = 0, ready_mode = 0;
  bit stray_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
  endtask

  task automatic push_expected(input logic [15:0] base, input logic [15:0] stride);
    logic [15:0] a;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a = base + 16'(r) * stride + 16'(c);
        addr_q.push_back(a);
        ld_q.push_back(4'(r * 4 + c));
      end
    end
    for (int i = 3; i <= 15; i++) win_q.push_back(4'(i));
  endtask

  // memory responder: grant after gnt_dly REQ cycles, data rv_dly cycles into WAIT
  initial begin
    int gcnt = 0, rcnt = 0;
    bit pend = 1'b0;
    mem_rd_gnt = 1'b0;
    mem_rd_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_rd_gnt = 1'b0;
      mem_rd_valid = 1'b0;
      if (!rst) begin
        pend = 1'b0;
        gcnt = 0;
      end else if (pend) begin
        if (rcnt == 0) begin
          mem_rd_valid = 1'b1;
          pend = 1'b0;
        end else rcnt--;
      end else if (mem_rd_req) begin
        if (addr_q.size() == 0) chk("unexpected_req", int'(mem_rd_req), 0);
        else begin
          chk("mem_addr", int'(mem_addr), int'(addr_q[0]));
          if (gcnt == gnt_dly) begin
            mem_rd_gnt = 1'b1;
            void'(addr_q.pop_front());
            gcnt = 0;
            pend = 1'b1;
            rcnt = rv_dly;
          end else begin
            if (stray_en && gcnt == 1) mem_rd_valid = 1'b1;
            gcnt++;
          end
        end
      end
    end
  end

  // PE responder
  initial begin
    logic [3:0] pat = 4'b1001;
    int pi = 0;
    win_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) win_ready = 1'b1;
      else begin
        win_ready = pat[pi];
        pi = (pi + 1) % 4;
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (buf_ld) begin
          if (ld_q.size() == 0) chk("unexpected_buf_ld", int'(buf_ld), 0);
          else chk("buf_row_col", int'({buf_row, buf_col}), int'(ld_q.pop_front()));
        end
        if (win_valid) begin
          if (win_q.size() == 0) chk("unexpected_win_valid", int'(win_valid), 0);
          else begin
            chk("buf_index", int'(buf_index), int'(win_q[0]));
            chk("win_last", int'(win_last), int'(win_q[0] == 4'd15));
            if (win_ready) void'(win_q.pop_front());
          end
        end
        if (done) done_seen++;
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_req"}, int'(mem_rd_req), 0);
    chk({tag, "_win_valid"}, int'(win_valid), 0);
    chk({tag, "_win_last"}, int'(win_last), 0);
    chk({tag, "_buf_ld"}, int'(buf_ld), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_buf_row_col"}, int'({buf_row, buf_col}), 0);
    chk({tag, "_buf_index"}, int'(buf_index), 3);
  endtask

  // One fill+sweep job. abort_at>0 resets the DUT at that cycle after start.
  task automatic run_job(input logic [15:0] base, input logic [15:0] stride,
                         input int gd, input int rd, input bit stray, input int rmode,
                         input int abort_at, input bit hold_start, input bit pre_started);
    int first_win = 0, done_k = 0;
    gnt_dly = gd; rv_dly = rd; stray_en = stray; ready_mode = rmode; done_seen = 0;
    if (!pre_started) begin
      @(posedge clk); #1;
      chk("busy_before_start", int'(busy), 0);
      base_addr = base;
      row_stride = stride;
      start = 1'b1;
    end
    push_expected(base, stride);
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    for (int k = 1; k < 3000 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_after_start", int'(busy), 1);
      if (win_valid && first_win == 0) begin
        first_win = k;
        chk("state_sweep", int'(state_dbg), int'(ST_SWEEP));
      end
      if (done) done_k = k;
      if (abort_at != 0 && k == abort_at) break;
    end
    if (abort_at != 0) begin
      #2 rst = 1'b0;
      addr_q.delete(); ld_q.delete(); win_q.delete();
      @(negedge clk);
      chk_reset("abort");
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_done_after_abort", done_seen, 0);
      chk("idle_after_abort", int'(busy), 0);
      return;
    end
    if (done_k == 0) begin
      total_cnt++;
      $display("FAIL job_timeout: no done within budget (base 0x%0h)", base);
    end
    if (gd == 0 && rd == 0) chk("sweep_start_cycle", first_win, 33);
    if (gd == 0 && rd == 0 && rmode == 0) chk("done_cycle", done_k, 46);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
    chk("done_count", done_seen, 1);
    chk("loads_remaining", ld_q.size(), 0);
    chk("addrs_remaining", addr_q.size(), 0);
    chk("windows_remaining", win_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    base_addr = 16'h0;
    row_stride = 16'h0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    #2 rst = 1'b1;

    // fast fill and unstalled sweep
    run_job(16'h0100, 16'h0010, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    // memory backpressure with a stray rvalid during REQ
    run_job(16'h0200, 16'h0040, 3, 2, 1'b1, 0, 0, 1'b0, 1'b0);
    // PE stalls
    run_job(16'h0300, 16'h0008, 0, 0, 1'b0, 1, 0, 1'b0, 1'b0);
    // reset mid-sweep, then a clean re-run
    run_job(16'h0100, 16'h0010, 0, 0, 1'b0, 0, 38, 1'b0, 1'b0);
    run_job(16'h0500, 16'h0020, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    // address wrap with start held high across the job and into the next one
    run_job(16'hFFFE, 16'h0001, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
    run_job(16'hFFFE, 16'h0001, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
